nap_tx_arbiter: RTL
===================

// Module: nap_tx_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter that shares one NAP transmit stream among NUM_REQ requesters.
//  A grant is held from the sop beat through the eop beat, so packets never interleave on the NoC.
//  Sits between the packet sources (loopback/echo engines, test generators) and the NAP tx interface.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  DATA_W    256  stream data width
//  ADDR_W    4    stream destination-address width
//  CNT_W     16   per-requester packet-counter width (PKT_STATS_EN only)
// PORTS
//  clk        in   1               clock
//  resetn     in   1               synchronous, active-low reset
//  req_valid  in   NUM_REQ         per-requester beat valid
//  req_ready  out  NUM_REQ         per-requester beat accepted
//  req_data   in   NUM_REQ*DATA_W  packed data, requester i at [i*DATA_W +: DATA_W]
//  req_addr   in   NUM_REQ*ADDR_W  packed destination address
//  req_sop    in   NUM_REQ         start-of-packet
//  req_eop    in   NUM_REQ         end-of-packet
//  tx_valid   out  1               to NAP
//  tx_ready   in   1               from NAP
//  tx_data    out  DATA_W          to NAP
//  tx_addr    out  ADDR_W          to NAP
//  tx_sop     out  1               to NAP
//  tx_eop     out  1               to NAP
//  grant      out  NUM_REQ         one-hot current owner; 0 when idle
//  busy       out  1               1 while a grant is held
//  pkt_count  out  NUM_REQ*CNT_W   packets forwarded per requester (PKT_STATS_EN only)
// BEHAVIOUR
//  - Transfer on any cycle where valid & ready are both high, on either side.
//  - Reset (resetn=0 at a clk edge), applied next cycle:
//    - state=IDLE, grant=0, busy=0, rr_ptr=0, pkt_count=0.
//    - Combinational outputs then read tx_valid=0, req_ready=0.
//  - States: IDLE, BUSY.
//  - IDLE:
//    - tx_valid=0 and req_ready=0 (no beat is accepted).
//    - If any req_valid is high, pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
//    - Register grant/owner and go to BUSY. Request-to-first-beat latency is 1 cycle.
//    - Arbitration looks only at req_valid. A source must present sop on its first beat.
//    - sop is forwarded, not checked.
//  - BUSY, owner g:
//    - tx_valid/data/addr/sop/eop = requester g fields, as a combinational mux (no added latency).
//    - req_ready[g] = tx_ready. All other req_ready = 0.
//  - Leaving BUSY: on an accepted beat with eop=1, go to IDLE next cycle, with rr_ptr = (g+1) mod NUM_REQ.
//    - Consequence: one idle cycle between packets. Max packet rate is 1 per (len+1) cycles.
//  - Single-beat packet (sop&eop on one beat): grant is released after that one beat.
//  - Owner drops req_valid mid-packet: grant is held and tx_valid=0. There is no timeout.
//  - tx_ready low: the owner is stalled. Non-owner req_valid has no effect.
//  - Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
//  - Reset mid-packet: grant is dropped immediately and the partial packet is abandoned on both sides.
//    Upstream sources are reset by the same resetn.
//  - busy = (state == BUSY). grant is one-hot while BUSY and 0 in IDLE.
// CONFIGURATION
//  - PKT_STATS_EN defined:
//    - pkt_count[i] increments by 1 on each accepted eop beat from requester i.
//    - Wraps modulo 2^CNT_W. Cleared by reset.
//  - PKT_STATS_EN undefined: pkt_count is tied to 0 and no counter registers are built.
// TESTING
//  - Reset: resetn=0 for 3 cycles with all req_valid=1 -> tx_valid=0, req_ready=0, grant=0 and busy=0 throughout.
//  - Single source: req 2 sends a 3-beat packet with tx_ready=1 ->
//    - grant=4'b0100 one cycle after valid.
//    - tx beats match data/addr/sop/eop exactly.
//    - IDLE one cycle after eop.
//  - Round-robin: all 4 valid, each sends 2-beat packets continuously -> grant order 0,1,2,3,0.
//    Each packet is contiguous on tx, with no beat from another requester inside it.
//  - Backpressure: tx_ready toggles 1,0,0,1 during a packet from req 1 ->
//    - req_ready[1] follows tx_ready.
//    - No beat is lost or duplicated.
//    - req 0 and req 3 see req_ready=0.
//  - Mid-packet reset: resetn=0 after beat 2 of a 4-beat packet -> next cycle tx_valid=0, grant=0.
//    After release, rr_ptr=0 and requester 0 wins first.
//  - PKT_STATS_EN: req 3 sends 5 packets, single-beat and multi-beat -> pkt_count[3]=5, others 0.
//    With CNT_W=4, 17 packets give pkt_count[3]=1.

Source files
------------

// File: rtl/nap_tx_arbiter_if.sv
// Stream bundle between the packet sources, the tx arbiter and the NAP.
// The req_* signals carry NUM_REQ packed requester lanes; tx_* is the shared NAP lane.
// modport slave  : arbiter view (consumes requester beats, produces the NAP stream).
// modport master : environment view (sources drive req_*, the NAP drives tx_ready).
interface nap_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_sop;
  logic [NUM_REQ-1:0]        req_eop;
  logic                      tx_valid;
  logic                      tx_ready;
  logic [DATA_W-1:0]         tx_data;
  logic [ADDR_W-1:0]         tx_addr;
  logic                      tx_sop;
  logic                      tx_eop;

  modport slave (
    input  req_valid, req_data, req_addr, req_sop, req_eop, tx_ready,
    output req_ready, tx_valid, tx_data, tx_addr, tx_sop, tx_eop
  );

  modport master (
    output req_valid, req_data, req_addr, req_sop, req_eop, tx_ready,
    input  req_ready, tx_valid, tx_data, tx_addr, tx_sop, tx_eop
  );
endinterface

// File: rtl/nap_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing one NAP tx stream among NUM_REQ sources.
// A grant is taken in IDLE and held from the sop beat through the accepted eop beat,
// so packets never interleave. The owner's beat is muxed combinationally onto tx.
// Optional build macro: PKT_STATS_EN adds per-requester packet counters on pkt_count;
// when undefined pkt_count reads 0 and no counter registers exist.
module nap_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  nap_tx_arbiter_if.slave          bus,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [NUM_REQ*CNT_W-1:0] pkt_count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             tx_valid_c;
  logic             beat_fire;
  logic             eop_fire;
  logic [NUM_REQ-1:0] req_ready_c;
  logic [DATA_W-1:0]  tx_data_c;
  logic [ADDR_W-1:0]  tx_addr_c;
  logic               tx_sop_c;
  logic               tx_eop_c;

  // (base + off) mod NUM_REQ for off < NUM_REQ, without a divider
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Owner's beat onto the NAP lane; only the owner sees tx_ready
  always_comb begin
    tx_valid_c  = 1'b0;
    tx_data_c   = '0;
    tx_addr_c   = '0;
    tx_sop_c    = 1'b0;
    tx_eop_c    = 1'b0;
    req_ready_c = '0;
    if (state == BUSY) begin
      tx_valid_c         = bus.req_valid[owner];
      tx_data_c          = bus.req_data[32'(owner)*DATA_W +: DATA_W];
      tx_addr_c          = bus.req_addr[32'(owner)*ADDR_W +: ADDR_W];
      tx_sop_c           = bus.req_sop[owner];
      tx_eop_c           = bus.req_eop[owner];
      req_ready_c[owner] = bus.tx_ready;
    end
  end

  assign beat_fire = tx_valid_c & bus.tx_ready;
  assign eop_fire  = beat_fire & tx_eop_c;

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_data   = tx_data_c;
  assign bus.tx_addr   = tx_addr_c;
  assign bus.tx_sop    = tx_sop_c;
  assign bus.tx_eop    = tx_eop_c;
  assign bus.req_ready = req_ready_c;

  // Next-state: grab in IDLE, release after the accepted eop beat
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BUSY;
          owner_nxt = pick_idx;
        end
      end
      BUSY: begin
        if (eop_fire) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_add(owner, 1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // One-hot grant decoded from the registered owner
  always_comb begin
    grant = '0;
    if (state == BUSY) grant[owner] = 1'b1;
  end

  assign busy = (state == BUSY);

`ifdef PKT_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];

  // Count accepted eop beats per requester, wrapping naturally
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (eop_fire) begin
      cnt[owner] <= cnt[owner] + CNT_W'(1);
    end
  end

  // Pack the counters onto the flat output
  always_comb begin
    pkt_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) pkt_count[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign pkt_count = '0;
`endif

endmodule
